// File: rtl/peak_report_tx.sv
// Millisecond timebase and byte-framed peak report sender for the 48-bit peak detector.
// Optional CRC-8 trailer byte enabled by defining PEAK_REPORT_CRC_EN.
module peak_report_tx #(
    parameter int unsigned CLK_PER_MS  = 150000,
    parameter int unsigned CAPTURE_DLY = 3,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [47:0] max_in,
    output logic        ms_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic [7:0]  ovf_cnt
);

    localparam int unsigned CNT_W  = 24;
    localparam int unsigned DLY_W  = 4;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MAX_W  = 48;
`ifdef PEAK_REPORT_CRC_EN
    localparam int unsigned FRAME_LEN = 9;
`else
    localparam int unsigned FRAME_LEN = 8;
`endif

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_PER_MS - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(CAPTURE_DLY - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [BYTE_W-1:0] OVF_MAX  = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [CNT_W-1:0]  cnt_q;
    logic [DLY_W-1:0]  dly_cnt_q;
    logic              dly_act_q;
    logic              ms_set_c;
    logic              capture_c;
    logic              accept_c;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
    logic [MAX_W-1:0]  frame_max_q, frame_max_d;
    logic [BYTE_W-1:0] frame_seq_q, frame_seq_d;
    logic [BYTE_W-1:0] seq_q, seq_d;
    logic [BYTE_W-1:0] ovf_d;
    logic              valid_d, last_d;
    logic [BYTE_W-1:0] data_d;
`ifdef PEAK_REPORT_CRC_EN
    logic [BYTE_W-1:0] crc_q, crc_d;

    // CRC-8, poly 0x07, MSB first, one byte per call
    function automatic logic [BYTE_W-1:0] crc8_next(input logic [BYTE_W-1:0] crc,
                                                    input logic [BYTE_W-1:0] d);
        logic [BYTE_W-1:0] c;
        c = crc ^ d;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    assign ms_set_c  = en && (cnt_q == CNT_LAST);
    assign capture_c = dly_act_q && (dly_cnt_q == DLY_LAST);
    assign accept_c  = tx_valid && tx_ready;
    assign idx_nxt   = idx_q + IDX_W'(1);

    // Interval counter, ms strobe and capture delay; a pending capture survives en=0
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            ms_out    <= 1'b0;
            dly_act_q <= 1'b0;
            dly_cnt_q <= '0;
        end else begin
            if (!en) begin
                cnt_q  <= '0;
                ms_out <= 1'b0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q  <= '0;
                ms_out <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + CNT_W'(1);
                ms_out <= 1'b0;
            end

            if (ms_set_c) begin
                dly_act_q <= 1'b1;
                dly_cnt_q <= '0;
            end else if (dly_act_q) begin
                dly_cnt_q <= dly_cnt_q + DLY_W'(1);
                if (capture_c) begin
                    dly_act_q <= 1'b0;
                end
            end
        end
    end

    // Frame FSM: next state and registered byte stream
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_max_d = frame_max_q;
        frame_seq_d = frame_seq_q;
        seq_d       = seq_q;
        ovf_d       = ovf_cnt;
        valid_d     = tx_valid;
        data_d      = tx_data;
        last_d      = tx_last;
`ifdef PEAK_REPORT_CRC_EN
        crc_d       = crc_q;
`endif

        // every capture consumes a sequence number so gaps are visible downstream
        if (capture_c) begin
            seq_d = seq_q + BYTE_W'(1);
        end

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (capture_c) begin
                    frame_max_d = max_in;
                    frame_seq_d = seq_q;
                    idx_d       = '0;
                    valid_d     = 1'b1;
                    data_d      = HEADER;
                    state_d     = SEND;
`ifdef PEAK_REPORT_CRC_EN
                    crc_d       = '0;
`endif
                end
            end
            SEND: begin
                if (capture_c && (ovf_cnt != OVF_MAX)) begin
                    ovf_d = ovf_cnt + BYTE_W'(1);
                end
                if (accept_c) begin
`ifdef PEAK_REPORT_CRC_EN
                    crc_d = crc8_next(crc_q, tx_data);
`endif
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_nxt;
                        last_d = (idx_nxt == IDX_LAST);
                        case (idx_nxt)
                            4'd1:    data_d = frame_seq_q;
                            4'd2:    data_d = frame_max_q[47:40];
                            4'd3:    data_d = frame_max_q[39:32];
                            4'd4:    data_d = frame_max_q[31:24];
                            4'd5:    data_d = frame_max_q[23:16];
                            4'd6:    data_d = frame_max_q[15:8];
                            4'd7:    data_d = frame_max_q[7:0];
`ifdef PEAK_REPORT_CRC_EN
                            4'd8:    data_d = crc_d;
`endif
                            default: data_d = HEADER;
                        endcase
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            frame_max_q <= '0;
            frame_seq_q <= '0;
            seq_q       <= '0;
            ovf_cnt     <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            tx_last     <= 1'b0;
`ifdef PEAK_REPORT_CRC_EN
            crc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_max_q <= frame_max_d;
            frame_seq_q <= frame_seq_d;
            seq_q       <= seq_d;
            ovf_cnt     <= ovf_d;
            tx_valid    <= valid_d;
            tx_data     <= data_d;
            tx_last     <= last_d;
`ifdef PEAK_REPORT_CRC_EN
            crc_q       <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_peak_report_tx.sv
// Bench for peak_report_tx: cycle model of strobe/capture timing plus a byte scoreboard.
module tb_peak_report_tx;

    localparam int unsigned CLK_PER_MS  = 20;
    localparam int unsigned CAPTURE_DLY = 3;
    localparam logic [7:0]  HEADER      = 8'hA5;
`ifdef PEAK_REPORT_CRC_EN
    localparam int unsigned FRAME_LEN = 9;
`else
    localparam int unsigned FRAME_LEN = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [47:0] max_in;
    logic        ms_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic [7:0]  ovf_cnt;

    peak_report_tx #(
        .CLK_PER_MS (CLK_PER_MS),
        .CAPTURE_DLY(CAPTURE_DLY),
        .HEADER     (HEADER)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .max_in  (max_in),
        .ms_out  (ms_out),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_last (tx_last),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [47:0] max;
        logic        en;
        int unsigned mode;     // 0: ready=1, 1: ready 1,0,0,1, 2: ready=0
        int unsigned cycles;
        logic [7:0]  exp_ovf;
    } vec_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    bit          chk_en   = 1'b0;
    int unsigned m_cnt    = 0;
    bit          m_ms     = 1'b0;
    int unsigned m_dly    = 0;
    bit          m_busy   = 1'b0;
    bit          m_cap    = 1'b0;
    logic [7:0]  m_seq    = 8'h00;
    logic [7:0]  m_ovf    = 8'h00;
    bit          acc_last = 1'b0;
    int          byte_pos = 0;
    int          frames_done = 0;
    logic [7:0]  last_seq = 8'h00;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;
    logic        prev_last  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] crc_bitwise(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic push_frame(input logic [47:0] m, input logic [7:0] s);
        logic [7:0] b[9];
        logic [7:0] crc;
        b[0] = HEADER;
        b[1] = s;
        for (int k = 0; k < 6; k++) b[2+k] = m[47-8*k -: 8];
        crc = 8'h00;
        for (int k = 0; k < 8; k++) crc = crc_bitwise(crc, b[k]);
        b[8] = crc;
        for (int k = 0; k < int'(FRAME_LEN); k++) begin
            exp_q.push_back({b[k], (k == int'(FRAME_LEN) - 1) ? 1'b1 : 1'b0});
        end
    endtask

    // Reference model of timebase, capture delay and frame occupancy
    always @(posedge clk) begin
        if (rst) begin
            m_cnt      = 0;
            m_ms       = 1'b0;
            m_dly      = 0;
            m_busy     = 1'b0;
            m_seq      = 8'h00;
            m_ovf      = 8'h00;
            exp_q.delete();
            byte_pos   = 0;
            acc_last   = 1'b0;
            prev_stall = 1'b0;
            chk_en     = 1'b1;
        end else begin
            m_cap = (m_dly == 1);
            if (m_dly > 0) m_dly--;
            if (m_cap) begin
                if (m_busy) begin
                    if (m_ovf != 8'hFF) m_ovf++;
                end else begin
                    push_frame(max_in, m_seq);
                    m_busy = 1'b1;
                end
                m_seq++;
            end
            if (acc_last) m_busy = 1'b0;
            acc_last = 1'b0;
            if (!en) begin
                m_cnt = 0;
                m_ms  = 1'b0;
            end else if (m_cnt == CLK_PER_MS - 1) begin
                m_cnt = 0;
                m_ms  = 1'b1;
                m_dly = CAPTURE_DLY;
            end else begin
                m_cnt++;
                m_ms = 1'b0;
            end
        end
    end

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            check("ms_out", 64'(ms_out), 64'(m_ms));
            check("tx_valid", 64'(tx_valid), 64'(m_busy));
            check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
            if (prev_stall) begin
                check("hold_data", 64'(tx_data), 64'(prev_data));
                check("hold_last", 64'(tx_last), 64'(prev_last));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected no byte at %0t", tx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", 64'(tx_data), 64'(e.data));
                    check("tx_last", 64'(tx_last), 64'(e.last));
                    if (byte_pos == 1) last_seq = tx_data;
                    byte_pos = e.last ? 0 : byte_pos + 1;
                    if (e.last) frames_done++;
                    acc_last = e.last;
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    task automatic wait_frames(input int n, input string name);
        int target;
        bit done;
        target = frames_done + n;
        done   = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk); #1;
            if (frames_done >= target) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got %0d frames expected %0d (timeout)", name, frames_done, target);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[7];
        logic [3:0] pat;
        int         edges;
        bit         found;

        vecs[0] = '{48'h0123_4567_89AB, 1'b1, 0, 60, 8'd0};
        vecs[1] = '{48'h0123_4567_89AB, 1'b1, 1, 80, 8'd0};
        vecs[2] = '{48'h0000_0000_0000, 1'b1, 0, 50, 8'd0};
        vecs[3] = '{48'hFFFF_FFFF_FFFF, 1'b1, 1, 60, 8'd0};
        vecs[4] = '{48'h0000_0000_0000, 1'b0, 0, 30, 8'd0};
        vecs[5] = '{48'hA5A5_5A5A_0F0F, 1'b1, 2, 45, 8'd1};
        vecs[6] = '{48'hA5A5_5A5A_0F0F, 1'b1, 0, 40, 8'd1};
        pat = 4'b1001;

        rst = 1'b1; en = 1'b0; tx_ready = 1'b0; max_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_tx_data", 64'(tx_data), 64'(0));
        check("rst_tx_last", 64'(tx_last), 64'(0));
        check("rst_ovf_cnt", 64'(ovf_cnt), 64'(0));
        check("rst_ms_out", 64'(ms_out), 64'(0));

        rst = 1'b0; en = 1'b1; tx_ready = 1'b1; max_in = 48'h0123_4567_89AB;
        edges = 0; found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (ms_out) found = 1'b1;
        end
        check("first_ms_edge", 64'(edges), 64'(20));
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (tx_valid) found = 1'b1;
        end
        check("first_frame_edge", 64'(edges), 64'(23));
        wait_frames(1, "frame0_done");
        check("frame0_seq", 64'(last_seq), 64'(8'h00));
        wait_frames(1, "frame1_done");
        check("frame1_seq", 64'(last_seq), 64'(8'h01));

        @(posedge clk); #1;
        for (int v = 0; v < 7; v++) begin
            max_in = vecs[v].max;
            en     = vecs[v].en;
            for (int c = 0; c < int'(vecs[v].cycles); c++) begin
                tx_ready = (vecs[v].mode == 0) ? 1'b1 :
                           (vecs[v].mode == 1) ? pat[c % 4] : 1'b0;
                @(posedge clk); #1;
            end
            check($sformatf("vec%0d_ovf", v), 64'(ovf_cnt), 64'(vecs[v].exp_ovf));
        end

        // long stall: two captures dropped, next frame carries seq 3
        rst = 1'b1; tx_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0; en = 1'b1; max_in = 48'hA5A5_5A5A_0F0F;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(posedge clk); #1;
            if (tx_valid) found = 1'b1;
        end
        check("stall_frame_start", 64'(found), 64'(1));
        repeat (45) begin @(posedge clk); #1; end
        check("stall_ovf", 64'(ovf_cnt), 64'(2));
        tx_ready = 1'b1;
        wait_frames(2, "stall_frames");
        check("stall_next_seq", 64'(last_seq), 64'(8'h03));

        // reset while byte 4 is presented
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(posedge clk); #1;
            if (tx_valid && byte_pos == 4) found = 1'b1;
        end
        check("midframe_reached", 64'(found), 64'(1));
        check("midframe_byte4", 64'(tx_data), 64'(8'h5A));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_tx_valid", 64'(tx_valid), 64'(0));
        check("midrst_ovf", 64'(ovf_cnt), 64'(0));
        wait_frames(1, "post_rst_frame");
        check("post_rst_seq", 64'(last_seq), 64'(8'h00));

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
